sc1602_frame_scheduler: RTL and testbench
=========================================

Name: sc1602_frame_scheduler

Overview:
Owns a 2x16 character frame buffer for the SC1602 LCD and schedules its contents onto the LCD driver's command stream.
- Host logic writes characters at arbitrary times.
- The scheduler tracks dirty cells, issues a set-DDRAM-address command per row, then streams that row's 16 characters over a valid/ready handshake.
- Sits between application logic and the byte-level LCD driver; also forces a periodic full refresh.

Parameters:
REFRESH_CYCLES, 27_000_000, sys_clk cycles between forced full-screen refreshes (1 s at 27 MHz); 0 disables periodic refresh
ROW1_BASE, 8'h40, DDRAM base address of row 1 (row 0 base fixed 8'h00)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
wr_en  input  1  host write strobe, one cell per cycle
wr_addr  input  5  cell index: [4] = row, [3:0] = column
wr_data  input  8  character code
clear  input  1  pulse: fill buffer with 8'h20, mark all dirty
cmd_valid  output  1  command/data byte presented to driver
cmd_rs  output  1  0 = instruction, 1 = character data
cmd_byte  output  8  byte to driver
cmd_ready  input  1  driver accepts byte when high with cmd_valid at rising edge
busy  output  1  high whenever state != IDLE
row_done  output  1  one-cycle pulse after last character of a row is accepted

Behaviour:
- Reset (async, any time including mid-transfer):
  - buffer = 8'h20 in all 32 cells; all 32 dirty bits set; refresh counter = 0; state = IDLE.
  - cmd_valid = 0, cmd_rs = 0, cmd_byte = 8'h00, busy = 0, row_done = 0.
  - Consequence: the full screen is redrawn after every reset.
- Writes: wr_en stores wr_data at wr_addr on the rising edge and sets that cell's dirty bit. Accepted in every state.
- clear: same edge fills all cells with 8'h20 and sets all dirty bits. clear beats wr_en in the same cycle; the write is dropped.
- Refresh: counter increments each cycle. At REFRESH_CYCLES-1 it wraps to 0 and sets all dirty bits; buffer contents are unchanged.
- Handshake:
  - cmd_rs and cmd_byte are registered and stable while cmd_valid = 1.
  - Transfer happens on an edge with cmd_valid & cmd_ready.
  - cmd_valid never drops without a transfer except on reset.
  - cmd_ready while cmd_valid = 0 is ignored.
- FSM states: IDLE, LOAD_ADDR, SEND_ADDR, LOAD_CHAR, SEND_CHAR.
  - IDLE: if any dirty bit in row 0, select row 0; else if any in row 1, select row 1; else stay. On selection go to LOAD_ADDR, column = 0. Row 0 has priority.
  - LOAD_ADDR: register cmd_rs = 0, cmd_byte = 8'h80 | base(row), cmd_valid = 1, go to SEND_ADDR.
  - SEND_ADDR: hold until transfer, then cmd_valid = 0, go to LOAD_CHAR.
  - LOAD_CHAR: register cmd_rs = 1, cmd_byte = buffer[row][column], cmd_valid = 1, clear that cell's dirty bit, go to SEND_CHAR.
    - If wr_en or clear hits that cell on the same edge, the dirty bit stays set.
  - SEND_CHAR: hold until transfer.
    - If column = 15: pulse row_done, go to IDLE.
    - Else: column++, go to LOAD_CHAR.
- Whole-row granularity: any dirty cell causes all 16 cells of that row to be sent.
- Throughput: cmd_valid is low for exactly one cycle between consecutive commands (LOAD cycle). Minimum 2 cycles per byte with cmd_ready held high.
  - Row = 34 cycles minimum: 2 address + 32 character.
  - IDLE costs 1 cycle between rows.
- A cell written after its LOAD_CHAR (same pass) keeps its dirty bit and is resent on a later pass. The stale byte already in cmd_byte is still sent unchanged.

Decomposition:
- Package sc1602_pkg holds:
  - constants LCD_CMD_SET_DDRAM = 8'h80, LCD_CHAR_SPACE = 8'h20, LCD_COLS = 16, LCD_ROWS = 2;
  - the FSM state enum.
- One sub-module, sc1602_frame_buffer: 32x8 register array plus 32 dirty bits. It takes the write/clear/refresh-set inputs and a dirty-clear strobe, and exposes a read port plus per-row any-dirty flags.
- The scheduler FSM and refresh counter live in the top block.

Test Plan:
- Reset release, cmd_ready tied 1 -> bytes 8'h80, 16x 8'h20, 8'hC0, 16x 8'h20; cmd_rs 0 only on the address bytes; two row_done pulses; then busy = 0.
- Idle screen, write 8'h41 to addr 5'h13 -> row 1 only: 8'hC0, then 8'h20 x3, 8'h41, 8'h20 x12; row 0 not sent.
- cmd_ready low 10 cycles during SEND_CHAR -> cmd_valid, cmd_rs, cmd_byte held constant all 10 cycles; exactly one transfer when cmd_ready rises.
- Write 8'h42 to cell 2 on the edge the scheduler loads cell 2 (row 0 pass) -> the byte sent for cell 2 in that pass is the old value; row 0 is resent, now containing 8'h42.
- clear and wr_en (addr 0, 8'h5A) on the same edge -> cell 0 = 8'h20; both rows resent as all 8'h20.
- REFRESH_CYCLES = 100, no writes -> full two-row refresh starts within 2 cycles of each counter wrap. Assert sys_rst_n low mid-row -> cmd_valid = 0 immediately; full redraw after release.

Source files
------------

// File: rtl/sc1602_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc1602_pkg : shared constants and FSM state type for the SC1602 frame |
// | scheduler.                                          Revision: 1.0     |
// +----------------------------------------------------------------------+
package sc1602_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_CHAR_SPACE    = 8'h20;
  localparam int         LCD_COLS          = 16;
  localparam int         LCD_ROWS          = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_ADDR = 3'd1,
    ST_SEND_ADDR = 3'd2,
    ST_LOAD_CHAR = 3'd3,
    ST_SEND_CHAR = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sc1602_frame_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc1602_frame_buffer : 32x8 character store with per-cell dirty bits.  |
// |                                                     Revision: 1.0     |
// +----------------------------------------------------------------------+
module sc1602_frame_buffer
  import sc1602_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_clear,
  input  logic       i_set_all_dirty,
  input  logic       i_dirty_clr,
  input  logic [4:0] i_dirty_clr_idx,
  input  logic [4:0] i_rd_idx,
  output logic [7:0] o_rd_data,
  output logic       o_row0_dirty,
  output logic       o_row1_dirty
);

  localparam int c_CELLS = LCD_ROWS * LCD_COLS;

  logic [7:0]         r_mem [c_CELLS];
  logic [c_CELLS-1:0] r_dirty;

  // Set sources are ordered after the scheduler's clear so a write landing
  // on the cell being loaded keeps that cell dirty for the next pass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < c_CELLS; i++) begin
        r_mem[i] <= LCD_CHAR_SPACE;
      end
      r_dirty <= '1;
    end else begin
      if (i_dirty_clr) begin
        r_dirty[i_dirty_clr_idx] <= 1'b0;
      end
      if (i_set_all_dirty) begin
        r_dirty <= '1;
      end
      if (i_clear) begin
        for (int i = 0; i < c_CELLS; i++) begin
          r_mem[i] <= LCD_CHAR_SPACE;
        end
        r_dirty <= '1;
      end else if (i_wr_en) begin
        r_mem[i_wr_addr]   <= i_wr_data;
        r_dirty[i_wr_addr] <= 1'b1;
      end
    end
  end

  assign o_rd_data    = r_mem[i_rd_idx];
  assign o_row0_dirty = |r_dirty[LCD_COLS-1:0];
  assign o_row1_dirty = |r_dirty[c_CELLS-1:LCD_COLS];

endmodule
`default_nettype wire

// File: rtl/sc1602_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc1602_frame_scheduler : streams dirty rows of the 2x16 frame buffer  |
// | to the LCD driver as address + 16 character bytes. Revision: 1.0      |
// +----------------------------------------------------------------------+
module sc1602_frame_scheduler
  import sc1602_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 27_000_000,
  parameter logic [7:0]  ROW1_BASE      = 8'h40
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clear,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       row_done
);

  sched_state_t r_state;
  logic         r_row;
  logic [3:0]   r_col;
  logic         r_cmd_valid;
  logic         r_cmd_rs;
  logic [7:0]   r_cmd_byte;
  logic         r_row_done;

  logic       w_refresh;
  logic       w_dirty_clr;
  logic [4:0] w_cell_idx;
  logic [7:0] w_rd_data;
  logic       w_row0_dirty;
  logic       w_row1_dirty;

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam logic [31:0] c_REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
      logic [31:0] r_refresh_cnt;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_refresh_cnt <= '0;
        end else if (r_refresh_cnt == c_REFRESH_LAST) begin
          r_refresh_cnt <= '0;
        end else begin
          r_refresh_cnt <= r_refresh_cnt + 32'd1;
        end
      end

      assign w_refresh = (r_refresh_cnt == c_REFRESH_LAST);
    end else begin : g_no_refresh
      assign w_refresh = 1'b0;
    end
  endgenerate

  assign w_cell_idx  = {r_row, r_col};
  assign w_dirty_clr = (r_state == ST_LOAD_CHAR);

  sc1602_frame_buffer u_frame_buffer (
    .i_clk           (sys_clk),
    .i_rst_n         (sys_rst_n),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .i_clear         (clear),
    .i_set_all_dirty (w_refresh),
    .i_dirty_clr     (w_dirty_clr),
    .i_dirty_clr_idx (w_cell_idx),
    .i_rd_idx        (w_cell_idx),
    .o_rd_data       (w_rd_data),
    .o_row0_dirty    (w_row0_dirty),
    .o_row1_dirty    (w_row1_dirty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_row       <= 1'b0;
      r_col       <= 4'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_rs    <= 1'b0;
      r_cmd_byte  <= 8'h00;
      r_row_done  <= 1'b0;
    end else begin
      r_row_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_row0_dirty) begin
            r_row   <= 1'b0;
            r_col   <= 4'd0;
            r_state <= ST_LOAD_ADDR;
          end else if (w_row1_dirty) begin
            r_row   <= 1'b1;
            r_col   <= 4'd0;
            r_state <= ST_LOAD_ADDR;
          end
        end
        ST_LOAD_ADDR: begin
          r_cmd_rs    <= 1'b0;
          r_cmd_byte  <= LCD_CMD_SET_DDRAM | (r_row ? ROW1_BASE : 8'h00);
          r_cmd_valid <= 1'b1;
          r_state     <= ST_SEND_ADDR;
        end
        ST_SEND_ADDR: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_LOAD_CHAR;
          end
        end
        ST_LOAD_CHAR: begin
          r_cmd_rs    <= 1'b1;
          r_cmd_byte  <= w_rd_data;
          r_cmd_valid <= 1'b1;
          r_state     <= ST_SEND_CHAR;
        end
        ST_SEND_CHAR: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (r_col == 4'(LCD_COLS - 1)) begin
              r_row_done <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_col   <= r_col + 4'd1;
              r_state <= ST_LOAD_CHAR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_rs    = r_cmd_rs;
  assign cmd_byte  = r_cmd_byte;
  assign row_done  = r_row_done;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sc1602_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sc1602_frame_scheduler : directed bench for the frame scheduler.   |
// |                                                     Revision: 1.0     |
// +----------------------------------------------------------------------+
module tb_sc1602_frame_scheduler;

  logic       clk;
  logic       rst_n, rst2_n;
  logic       wr_en, clear, cmd_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_valid, cmd_rs, busy, row_done;
  logic [7:0] cmd_byte;

  logic       wr_en2, clear2, cmd_ready2;
  logic [4:0] wr_addr2;
  logic [7:0] wr_data2;
  logic       cmd_valid2, cmd_rs2, busy2, row_done2;
  logic [7:0] cmd_byte2;

  int         vectors;
  int         fails;
  logic [7:0] exp_buf [32];

  sc1602_frame_scheduler #(.REFRESH_CYCLES(0), .ROW1_BASE(8'h40)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_byte  (cmd_byte),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .row_done  (row_done)
  );

  sc1602_frame_scheduler #(.REFRESH_CYCLES(100), .ROW1_BASE(8'h40)) dut_r (
    .sys_clk   (clk),
    .sys_rst_n (rst2_n),
    .wr_en     (wr_en2),
    .wr_addr   (wr_addr2),
    .wr_data   (wr_data2),
    .clear     (clear2),
    .cmd_valid (cmd_valid2),
    .cmd_rs    (cmd_rs2),
    .cmd_byte  (cmd_byte2),
    .cmd_ready (cmd_ready2),
    .busy      (busy2),
    .row_done  (row_done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a negedge where the next rising edge will transfer.
  task automatic get_xfer(output int n, output logic rs, output logic [7:0] b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_valid === 1'b1 && cmd_ready === 1'b1) && n < 200);
    chk("xfer wait bound", 32'(n < 200), 32'd1);
    rs = cmd_rs;
    b  = cmd_byte;
  endtask

  task automatic expect_row(input int row, input int stall_col, input int race_col,
                            input logic [7:0] race_data);
    int         n;
    logic       rs;
    logic [7:0] b;
    get_xfer(n, rs, b);
    chk($sformatf("row%0d addr latency", row), n, 2);
    chk($sformatf("row%0d addr rs", row), rs, 0);
    chk($sformatf("row%0d addr byte", row), b, (row == 1) ? 8'hC0 : 8'h80);
    for (int c = 0; c < 16; c++) begin
      if (c == stall_col) begin
        @(negedge clk);
        chk($sformatf("row%0d col%0d load gap", row, c), cmd_valid, 0);
        cmd_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk($sformatf("row%0d col%0d stall hold", row, c), {cmd_valid, cmd_rs, cmd_byte},
              {1'b1, 1'b1, exp_buf[row*16+c]});
        end
        cmd_ready = 1'b1;
        rs = cmd_rs;
        b  = cmd_byte;
      end else if (c == race_col) begin
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'(row * 16 + c);
        wr_data = race_data;
        @(negedge clk);
        wr_en = 1'b0;
        chk($sformatf("row%0d col%0d race valid", row, c), cmd_valid, 1);
        rs = cmd_rs;
        b  = cmd_byte;
      end else begin
        get_xfer(n, rs, b);
        chk($sformatf("row%0d col%0d latency", row, c), n, 2);
      end
      chk($sformatf("row%0d col%0d rs", row, c), rs, 1);
      chk($sformatf("row%0d col%0d byte", row, c), b, exp_buf[row*16+c]);
    end
    @(negedge clk);
    chk($sformatf("row%0d row_done", row), row_done, 1);
    chk($sformatf("row%0d busy after", row), busy, 0);
  endtask

  initial begin
    vectors = 0; fails = 0;
    clk = 1'b0; rst_n = 1'b0; rst2_n = 1'b0;
    wr_en = 1'b0; clear = 1'b0; cmd_ready = 1'b1; wr_addr = '0; wr_data = '0;
    wr_en2 = 1'b0; clear2 = 1'b0; cmd_ready2 = 1'b1; wr_addr2 = '0; wr_data2 = '0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

    repeat (3) @(negedge clk);
    chk("reset cmd_valid", cmd_valid, 0);
    chk("reset cmd_rs", cmd_rs, 0);
    chk("reset cmd_byte", cmd_byte, 8'h00);
    chk("reset busy", busy, 0);
    chk("reset row_done", row_done, 0);
    chk("reset2 cmd_valid", cmd_valid2, 0);

    // Post-reset full redraw.
    rst_n = 1'b1;
    expect_row(0, -1, -1, 8'h00);
    expect_row(1, -1, -1, 8'h00);
    @(negedge clk);
    chk("idle after redraw busy", busy, 0);
    chk("idle after redraw valid", cmd_valid, 0);

    // Single write in row 1 sends only row 1.
    wr_en = 1'b1; wr_addr = 5'h13; wr_data = 8'h41;
    @(negedge clk);
    wr_en = 1'b0;
    exp_buf[19] = 8'h41;
    expect_row(1, -1, -1, 8'h00);
    repeat (3) @(negedge clk);
    chk("row0 not sent busy", busy, 0);

    // Row 0 pass with a stall on column 8 and a write racing the load of cell 2.
    wr_en = 1'b1; wr_addr = 5'h05; wr_data = 8'h33;
    @(negedge clk);
    wr_en = 1'b0;
    exp_buf[5] = 8'h33;
    expect_row(0, 8, 2, 8'h42);
    exp_buf[2] = 8'h42;
    expect_row(0, -1, -1, 8'h00);
    repeat (3) @(negedge clk);
    chk("after resend busy", busy, 0);

    // clear wins over a simultaneous write.
    clear = 1'b1; wr_en = 1'b1; wr_addr = 5'h00; wr_data = 8'h5A;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    expect_row(0, -1, -1, 8'h00);
    expect_row(1, -1, -1, 8'h00);
    repeat (2) @(negedge clk);
    chk("after clear busy", busy, 0);

    // Periodic refresh (100 cycles) and async reset mid-row.
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (99) @(negedge clk);
    chk("refresh n99 busy", busy2, 0);
    @(negedge clk);
    chk("refresh n100 busy", busy2, 0);
    @(negedge clk);
    chk("refresh n101 busy", busy2, 1);
    @(negedge clk);
    chk("refresh n102 valid", cmd_valid2, 1);
    chk("refresh n102 rs", cmd_rs2, 0);
    chk("refresh n102 byte", cmd_byte2, 8'h80);
    repeat (98) @(negedge clk);
    chk("refresh n200 busy", busy2, 0);
    @(negedge clk);
    chk("refresh n201 busy", busy2, 1);
    @(negedge clk);
    chk("refresh n202 byte", {cmd_valid2, cmd_byte2}, {1'b1, 8'h80});
    repeat (12) @(negedge clk);
    chk("midrow valid", {cmd_valid2, cmd_rs2, cmd_byte2}, {1'b1, 1'b1, 8'h20});
    rst2_n = 1'b0;
    #1;
    chk("async reset valid", cmd_valid2, 0);
    chk("async reset rs", cmd_rs2, 0);
    chk("async reset byte", cmd_byte2, 8'h00);
    chk("async reset busy", busy2, 0);
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("redraw n1 busy", busy2, 1);
    @(negedge clk);
    chk("redraw n2 addr", {cmd_valid2, cmd_rs2, cmd_byte2}, {1'b1, 1'b0, 8'h80});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
